// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: state encoding,
// opcode values, strobe bundle and the per-state strobe decode.
package cpu_ctrl_pkg;

   localparam int MEM_TIMEOUT_DEFAULT = 8;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH_PC = 4'd1,
      S_FETCH_RD = 4'd2,
      S_FETCH_IR = 4'd3,
      S_DECODE   = 4'd4,
      S_EX_ADDR  = 4'd5,
      S_LOAD     = 4'd6,
      S_STORE    = 4'd7,
      S_JUMP     = 4'd8,
      S_OUTY     = 4'd9,
      S_HALT     = 4'd10,
      S_FAULT    = 4'd11
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_JMP   = 4'h3;
   localparam logic [3:0] OP_OUTY  = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef struct packed {
      logic pc_in;
      logic pc_out;
      logic pc_inc;
      logic mar_in;
      logic mar_mramout;
      logic mbr_in;
      logic mbr_out;
      logic dram_in;
      logic dram_out;
      logic ir_in;
      logic ir_out;
      logic y_in;
      logic en;
      logic halted;
      logic fault;
   } strobes_t;

   // Every strobe a state raises; anything not named here stays low, which
   // keeps pc_out/mbr_out/ir_out mutually exclusive and en tied to mar_mramout.
   function automatic strobes_t decode_strobes(state_t s);
      strobes_t st;
      st = '0;
      case (s)
         S_FETCH_PC: begin st.pc_out = 1'b1; st.mar_in = 1'b1; end
         S_FETCH_RD: begin st.mar_mramout = 1'b1; st.en = 1'b1; end
         S_FETCH_IR: begin st.mbr_out = 1'b1; st.ir_in = 1'b1; st.pc_inc = 1'b1; end
         S_EX_ADDR:  begin st.ir_out = 1'b1; st.mar_in = 1'b1; end
         S_LOAD:     begin st.mar_mramout = 1'b1; st.en = 1'b1; st.dram_out = 1'b1; st.mbr_in = 1'b1; end
         S_STORE:    begin st.mar_mramout = 1'b1; st.en = 1'b1; st.mbr_out = 1'b1; st.dram_in = 1'b1; end
         S_JUMP:     begin st.ir_out = 1'b1; st.pc_in = 1'b1; end
         S_OUTY:     begin st.mbr_out = 1'b1; st.y_in = 1'b1; end
         S_HALT:     st.halted = 1'b1;
         S_FAULT:    st.fault = 1'b1;
         default:    st = '0;
      endcase
      return st;
   endfunction

   // Opcodes 5..E have no meaning and are executed as NOP.
   function automatic logic is_illegal(logic [3:0] op);
      return !(op inside {OP_NOP, OP_LOAD, OP_STORE, OP_JMP, OP_OUTY, OP_HALT});
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Handshake and strobe bundle between the sequencer (master) and the
// datapath/memory side (slave).
interface ctrl_sequencer_if;

   logic       run;
   logic       mem_ready;
   logic [3:0] opcode;

   logic       pc_in;
   logic       pc_out;
   logic       pc_inc;
   logic       mar_in;
   logic       mar_mramout;
   logic       mbr_in;
   logic       mbr_out;
   logic       dram_in;
   logic       dram_out;
   logic       ir_in;
   logic       ir_out;
   logic       y_in;
   logic       en;
   logic [3:0] state;
   logic       halted;
   logic       fault;
   logic       illegal;

   modport master (
      input  run, mem_ready, opcode,
      output pc_in, pc_out, pc_inc, mar_in, mar_mramout, mbr_in, mbr_out,
             dram_in, dram_out, ir_in, ir_out, y_in, en, state, halted,
             fault, illegal
   );

   modport slave (
      output run, mem_ready, opcode,
      input  pc_in, pc_out, pc_inc, mar_in, mar_mramout, mbr_in, mbr_out,
             dram_in, dram_out, ir_in, ir_out, y_in, en, state, halted,
             fault, illegal
   );

endinterface

// File: rtl/ctrl_sequencer_mem_wait_timer.sv
// Counts wait cycles spent in a memory state and flags the last allowed one.
module mem_wait_timer #(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic timeout
);

   localparam int W = $clog2(MAX_WAIT + 1);
   localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

   logic [W-1:0] count;

   assign timeout = (count == LAST);

   // Held at zero outside memory states so each entry starts fresh; saturates at LAST.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && !timeout) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore micro-sequencer owning every bus-transfer strobe of the CPU
// datapath: fetch, decode and execute with a bounded memory-ready wait.
module ctrl_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   ctrl_sequencer_if.master  bus
);

   state_t     state_q;
   state_t     next_state;
   strobes_t   strobe_q;
   logic [3:0] op_q;
   logic       in_mem_state;
   logic       timeout;

   assign in_mem_state = (state_q == S_FETCH_RD) || (state_q == S_LOAD) || (state_q == S_STORE);

   mem_wait_timer #(
      .MAX_WAIT (MEM_TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (!in_mem_state),
      .count_en (in_mem_state && !bus.mem_ready),
      .timeout  (timeout)
   );

   // Next-state selection; mem_ready takes priority over an expiring wait.
   always_comb begin
      next_state = state_q;
      case (state_q)
         S_IDLE:     next_state = S_FETCH_PC;
         S_FETCH_PC: if (bus.run) next_state = S_FETCH_RD;
         S_FETCH_RD: begin
            if (bus.mem_ready)  next_state = S_FETCH_IR;
            else if (timeout)   next_state = S_FAULT;
         end
         S_FETCH_IR: next_state = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: next_state = S_EX_ADDR;
               OP_JMP:            next_state = S_JUMP;
               OP_OUTY:           next_state = S_OUTY;
               OP_HALT:           next_state = S_HALT;
               default:           next_state = S_FETCH_PC;
            endcase
         end
         S_EX_ADDR:  next_state = (op_q == OP_STORE) ? S_STORE : S_LOAD;
         S_LOAD, S_STORE: begin
            if (bus.mem_ready)  next_state = S_FETCH_PC;
            else if (timeout)   next_state = S_FAULT;
         end
         S_JUMP, S_OUTY: next_state = S_FETCH_PC;
         S_HALT:     next_state = S_HALT;
         S_FAULT:    next_state = S_FAULT;
         default:    next_state = S_IDLE;
      endcase
   end

   // State, registered strobes (decoded from the upcoming state) and opcode latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         strobe_q <= '0;
         op_q     <= OP_NOP;
      end else begin
         state_q  <= next_state;
         strobe_q <= decode_strobes(next_state);
         if (state_q == S_DECODE) begin
            op_q <= bus.opcode;
         end
      end
   end

   assign bus.pc_in       = strobe_q.pc_in;
   assign bus.pc_out      = strobe_q.pc_out;
   assign bus.pc_inc      = strobe_q.pc_inc;
   assign bus.mar_in      = strobe_q.mar_in;
   assign bus.mar_mramout = strobe_q.mar_mramout;
   assign bus.mbr_in      = strobe_q.mbr_in;
   assign bus.mbr_out     = strobe_q.mbr_out;
   assign bus.dram_in     = strobe_q.dram_in;
   assign bus.dram_out    = strobe_q.dram_out;
   assign bus.ir_in       = strobe_q.ir_in;
   assign bus.ir_out      = strobe_q.ir_out;
   assign bus.y_in        = strobe_q.y_in;
   assign bus.en          = strobe_q.en;
   assign bus.halted      = strobe_q.halted;
   assign bus.fault       = strobe_q.fault;
   assign bus.state       = state_q;
   assign bus.illegal     = (state_q == S_DECODE) && is_illegal(bus.opcode);

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Micro-sequencer that drives the register-transfer strobes of the 4-bit-address / 8-bit-data CPU datapath (PC, MAR, MBR, IR, data RAM, Y latch). It runs fetch, decode and execute phases as a Moore FSM. It waits on a memory-ready handshake with a bounded timeout, and it replaces the free-running strobe controller as the single owner of every bus-transfer enable. Opcode comes from the IR high nibble; operand address from the low nibble (routed by the datapath, not this block).

## Interface
- MEM_TIMEOUT, 8: max cycles spent waiting for `mem_ready` in one memory state before faulting (1..255).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- run  input  1  level; sequencer leaves S_FETCH_PC only while 1 (stall/pause between instructions).
- mem_ready  input  1  memory access complete this cycle (instruction or data RAM).
- opcode  input  4  IR[7:4], sampled in S_DECODE.
- pc_in, pc_out, pc_inc  output  1 each  PC load / drive-bus / increment.
- mar_in, mar_mramout  output  1 each  MAR load / drive address to memory.
- mbr_in, mbr_out  output  1 each  MBR load from bus / drive bus.
- dram_in, dram_out  output  1 each  data RAM write / read.
- ir_in, ir_out  output  1 each  IR load / drive operand onto bus.
- y_in  output  1  Y output latch load.
- en  output  1  memory enable.
- state  output  4  current state code (debug).
- halted  output  1  in S_HALT.
- fault  output  1  in S_FAULT (sticky).
- illegal  output  1  one-cycle pulse on undefined opcode.

## Operation
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 JMP, 4 OUTY, F HALT; 5–E illegal (executed as NOP, `illegal` pulses in S_DECODE).
- States and strobes (only listed strobes high, all others 0):
  - S_IDLE: none; always → S_FETCH_PC.
  - S_FETCH_PC: pc_out, mar_in; → S_FETCH_RD if run else stay.
  - S_FETCH_RD: mar_mramout, en; → S_FETCH_IR on mem_ready.
  - S_FETCH_IR: mbr_out, ir_in, pc_inc; → S_DECODE.
  - S_DECODE: none; NOP/illegal → S_FETCH_PC; LOAD/STORE → S_EX_ADDR; JMP → S_JUMP; OUTY → S_OUTY; HALT → S_HALT.
  - S_EX_ADDR: ir_out, mar_in; → S_LOAD or S_STORE by latched opcode.
  - S_LOAD: mar_mramout, en, dram_out, mbr_in; → S_FETCH_PC on mem_ready.
  - S_STORE: mar_mramout, en, mbr_out, dram_in; → S_FETCH_PC on mem_ready.
  - S_JUMP: ir_out, pc_in; → S_FETCH_PC.
  - S_OUTY: mbr_out, y_in; → S_FETCH_PC.
  - S_HALT: halted; terminal until reset.
  - S_FAULT: fault; terminal until reset.
- Opcode latched into an internal register in S_DECODE; `opcode` ignored elsewhere.
- Wait counter (width ceil(log2(MEM_TIMEOUT+1))): cleared on entry to S_FETCH_RD/S_LOAD/S_STORE, increments each cycle there without mem_ready; when it reaches MEM_TIMEOUT−1 with mem_ready low → S_FAULT.
- mem_ready and timeout in same cycle: mem_ready wins.
- mem_ready outside memory states: ignored.
- No two bus drivers (pc_out, mbr_out, ir_out) ever high together; `en` high only with mar_mramout.

## Timing
- Reset: state = S_IDLE, all strobes 0, halted/fault/illegal 0, counter 0, latched opcode 0.
- Strobes are pure decode of the state register (Moore); no input-to-output combinational paths except none — `illegal` also decoded from registered state plus latched/sampled opcode in S_DECODE.
- Zero-wait memory (mem_ready high on first memory cycle): NOP 4 cycles (FETCH_PC→FETCH_RD→FETCH_IR→DECODE); JMP/OUTY 5; LOAD/STORE 6. Each wait cycle adds 1.
- Reset asserted mid-instruction: strobes drop to 0 asynchronously; no partial transfer completes.
- PC wrap (F→0) is the PC's concern; sequencer unaffected.

## Structure
- Package `cpu_ctrl_pkg`: state enum (4-bit codes), opcode constants, MEM_TIMEOUT default.
- One natural sub-module: `mem_wait_timer` (clear, count, timeout flag).
- Strobe decode as a single case on state.

## Test plan
- Reset then run=1, NOP at PC 0, mem_ready tied 1 -> states IDLE,FETCH_PC,FETCH_RD,FETCH_IR,DECODE,FETCH_PC; pc_inc high exactly once.
- LOAD (0x15), mem_ready delayed 3 cycles in S_LOAD -> dram_out+mbr_in held 4 cycles, return to S_FETCH_PC; total 9 cycles.
- JMP (0x3A) -> ir_out+pc_in for one cycle in S_JUMP; illegal 0x7x -> illegal pulse 1 cycle, NOP path.
- MEM_TIMEOUT=4, mem_ready never asserted in S_FETCH_RD -> S_FAULT after 4 cycles, fault stays 1 until reset; ready on 4th cycle -> no fault.
- HALT (0xF0) -> halted=1, all strobes 0 forever; run=0 in S_FETCH_PC -> stalls, no strobe beyond pc_out/mar_in.
- Reset pulse during S_STORE -> dram_in drops immediately, restart at S_IDLE.
